// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/response, redirect, and the
// valid/ready delivery channel toward decode.
interface instr_fetch_queue_if #(
    parameter int INSTR_W = 18,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic [CNT_W-1:0]   queue_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_o, instr_pc, queue_count,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_o, instr_pc, queue_count,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with a PC-tagged FIFO toward decode and flush on redirect.
// Optional FETCH_STALL_COUNT_EN adds a saturating credit-stall cycle counter.
module instr_fetch_queue #(
    parameter int                INSTR_W  = 18,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk_i,
    input  logic reset_i,
    instr_fetch_queue_if.master bus
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles_o
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic               inflight_q, inflight_d;
    logic               hold_q;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [CNT_W:0] used;
    logic           credit_ok;
    logic           req;
    logic           push;
    logic           pop;
    logic           valid;

    // Pending response counts against capacity, so a full queue can never be overrun.
    // hold_q keeps the first post-reset cycle request-free.
    assign used      = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign credit_ok = !hold_q && (used < (CNT_W+1)'(DEPTH));
    assign req       = !reset_i && !bus.redirect_valid && credit_ok;
    // The response of a request issued just before a redirect returns in the
    // redirect cycle itself, so gating the write here discards it.
    assign push      = inflight_q && !reset_i && !bus.redirect_valid;
    assign valid     = !reset_i && !bus.redirect_valid && (count_q != '0);
    assign pop       = valid && bus.instr_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = reset_i ? RESET_PC : pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr_o     = instr_mem_q[head_q];
    assign bus.instr_pc    = pc_mem_q[head_q];
    assign bus.queue_count = reset_i ? '0 : count_q;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = 1'b0;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            count_d = '0;
            head_d  = tail_q;
        end else begin
            inflight_d = req;
            if (req) begin
                pc_d     = pc_q + 1'b1;
                req_pc_d = pc_q;
            end
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            hold_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[tail_q] <= bus.imem_rdata;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else if (!bus.redirect_valid && !credit_ok && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif
endmodule
